wb_arbiter: RTL
===============

# wb_arbiter

Write-back arbiter that shares the single regbank write port among N_REQ result producers (alu_p1 today; load/store and multiply units next). Each requester pushes {data, dest} into a private small FIFO over a valid/ready handshake; a round-robin arbiter drains at most one entry per cycle into a registered write port that drives regbank `write_data`/`write_address` directly. Sits between the execute stages and regbank, replacing the direct `alu_result` → regbank wiring.

## Interface

Parameters:
- `N_REQ`, 2: number of result producers (2..8).
- `DEPTH`, 2: entries per requester FIFO (power of two, ≥2).
- `DWIDTH`, 32: result data width.
- `AWIDTH`, 7: physical register address width.

Ports:
- `clk`, input, 1: sole clock; all state on rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `req_valid`, input, N_REQ: requester i presents a result.
- `req_ready`, output, N_REQ: FIFO i can accept this cycle.
- `req_data`, input, N_REQ×DWIDTH: result value per requester.
- `req_dest`, input, N_REQ×AWIDTH: physical destination per requester.
- `write_valid`, output, 1: write port carries a result this cycle.
- `write_data`, output, DWIDTH: to regbank `write_data`.
- `write_address`, output, AWIDTH: to regbank `write_address`; 0 when idle (physical register 0 is never written).
- `grant_id`, output, $clog2(N_REQ): requester of the current write (debug/trace).

## Operation

- Per-requester FIFO: `DEPTH` entries, read/write pointers with one extra wrap bit; full when pointers differ only in the wrap bit, empty when equal.
- Push: `req_valid[i] & req_ready[i]` with `req_dest[i] != 0` enqueues. A handshake with `req_dest[i] == 0` is accepted and discarded (no enqueue, no write).
- `req_ready[i]` = FIFO i not full; registered state only, no combinational path from any `req_valid`.
- Arbiter: round-robin pointer `last` holds the most recently granted index. Each cycle, candidates are the non-empty FIFOs; search starts at `last+1` modulo N_REQ and wraps. Winner is popped; `last` updates to winner. No candidate → `last` unchanged.
- Write register: on a grant, `write_valid`←1, `write_data`/`write_address`←popped entry, `grant_id`←winner. No grant → `write_valid`←0, `write_data`←0, `write_address`←0, `grant_id` holds.
- Simultaneous push and pop on the same FIFO allowed, including when full (pop frees a slot, but `req_ready` still reflects pre-pop full state that cycle).
- Equal `req_dest` from two requesters is not checked (renaming prevents it); writes occur in grant order.
- Starvation bound: a non-empty FIFO is granted within N_REQ cycles.

## Timing

- Reset values: `req_ready` all 1, `write_valid` 0, `write_data` 0, `write_address` 0, `grant_id` 0, `last` = N_REQ-1 (requester 0 wins first), all FIFOs empty.
- Latency (macro absent): push at edge t → earliest write port output after edge t+1 (2 cycles).
- Throughput: one write per cycle total; per requester, one per cycle when it is the sole candidate.
- Reset asserted mid-operation: all FIFO contents dropped, outputs return to reset values asynchronously; no partial write emitted after release.
- First edge after reset release: accepts pushes; first write no earlier than the following edge.

## Configuration

- `WB_ARB_BYPASS_EN` defined: a requester whose FIFO is empty is also a candidate with its live `req_valid & req_ready & (req_dest != 0)`; if it wins, the entry goes directly to the write register at edge t without enqueuing (1-cycle latency). Round-robin order and `last` update are identical.
- Absent: only FIFO heads are candidates; minimum latency 2 cycles. `req_ready` behaviour is identical in both builds.

## Test plan

- Reset: hold `reset` 3 cycles mid-traffic with FIFO 1 holding 2 entries → all outputs at reset values immediately, `req_ready`=2'b11, no write after release until new push.
- Single requester: push {0xDEADBEEF, dest 5} on req 0 → `write_valid`=1, `write_address`=5, `write_data`=0xDEADBEEF 2 cycles later (1 with `WB_ARB_BYPASS_EN`), `grant_id`=0.
- Contention: both requesters push every cycle, dests 1,2,3 (req 0) and 65,66,67 (req 1) → write sequence 1,65,2,66,3,67 with `write_valid` continuously high.
- Backpressure: req 0 pushes 3 entries while req 1 streams, DEPTH=2 → `req_ready[0]`=0 after 2 queued, third accepted only after a pop; no entry lost or duplicated.
- Dest 0 drop: push {0x1234, dest 0} on req 1 → handshake completes, `write_valid` stays 0, `write_address` stays 0.
- Wrap-around: 10 push/pop cycles through FIFO 0 with DEPTH=2 → data order preserved across pointer wrap, empty/full flags correct at every cycle.

Source files
------------

// File: rtl/wb_arbiter.sv
// Round-robin write-back arbiter: N_REQ small FIFOs drained one entry per cycle into a registered regbank write port.
// Optional build macro WB_ARB_BYPASS_EN lets an empty FIFO's live push win directly (1-cycle latency).
module wb_arbiter #(
  parameter int unsigned N_REQ  = 2,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned AWIDTH = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*DWIDTH-1:0]    req_data,
  input  logic [N_REQ*AWIDTH-1:0]    req_dest,
  output logic                       write_valid,
  output logic [DWIDTH-1:0]          write_data,
  output logic [AWIDTH-1:0]          write_address,
  output logic [$clog2(N_REQ)-1:0]   grant_id
);

  localparam int unsigned GW = $clog2(N_REQ);
  localparam int unsigned PW = $clog2(DEPTH);

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [AWIDTH-1:0] dest;
  } entry_t;

  entry_t            r_mem  [N_REQ][DEPTH];
  logic [PW:0]       r_wptr [N_REQ];
  logic [PW:0]       r_rptr [N_REQ];
  logic [GW-1:0]     r_last;
  logic              r_write_valid;
  logic [DWIDTH-1:0] r_write_data;
  logic [AWIDTH-1:0] r_write_address;
  logic [GW-1:0]     r_grant_id;

  entry_t            w_live [N_REQ];
  entry_t            w_sel;
  logic [N_REQ-1:0]  w_full;
  logic [N_REQ-1:0]  w_empty;
  logic [N_REQ-1:0]  w_push_ok;
  logic [N_REQ-1:0]  w_enq;
  logic [N_REQ-1:0]  w_pop;
  logic [N_REQ-1:0]  w_cand;
  logic              w_gnt_vld;
  logic [GW-1:0]     w_gnt;

  // Per-requester FIFO status, push qualification and pointer/storage update
  for (genvar i = 0; i < N_REQ; i++) begin : gen_req
    assign w_live[i].data = req_data[i*DWIDTH +: DWIDTH];
    assign w_live[i].dest = req_dest[i*AWIDTH +: AWIDTH];
    assign w_empty[i]     = (r_wptr[i] == r_rptr[i]);
    assign w_full[i]      = (r_wptr[i][PW] != r_rptr[i][PW]) &&
                            (r_wptr[i][PW-1:0] == r_rptr[i][PW-1:0]);
    // Dest-0 handshakes complete but never reach the write port
    assign w_push_ok[i]   = req_valid[i] & ~w_full[i] & (w_live[i].dest != '0);
    assign w_pop[i]       = w_gnt_vld & (w_gnt == GW'(i)) & ~w_empty[i];
`ifdef WB_ARB_BYPASS_EN
    assign w_cand[i]      = ~w_empty[i] | w_push_ok[i];
    assign w_enq[i]       = w_push_ok[i] & ~(w_gnt_vld & (w_gnt == GW'(i)) & w_empty[i]);
`else
    assign w_cand[i]      = ~w_empty[i];
    assign w_enq[i]       = w_push_ok[i];
`endif

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        r_wptr[i] <= '0;
        r_rptr[i] <= '0;
      end else begin
        if (w_enq[i]) r_wptr[i] <= r_wptr[i] + (PW+1)'(1);
        if (w_pop[i]) r_rptr[i] <= r_rptr[i] + (PW+1)'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (w_enq[i]) r_mem[i][r_wptr[i][PW-1:0]] <= w_live[i];
    end
  end

  assign req_ready = ~w_full;

  // Round-robin search starting just after the last winner
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt     = r_last;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      int unsigned idx;
      idx = (32'(r_last) + k) % N_REQ;
      if (!w_gnt_vld && w_cand[idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt     = GW'(idx);
      end
    end
  end

  always_comb begin
    w_sel = r_mem[w_gnt][r_rptr[w_gnt][PW-1:0]];
`ifdef WB_ARB_BYPASS_EN
    if (w_empty[w_gnt]) w_sel = w_live[w_gnt];
`endif
  end

  // Registered write port; grant_id holds across idle cycles for tracing
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last          <= GW'(N_REQ - 1);
      r_write_valid   <= 1'b0;
      r_write_data    <= '0;
      r_write_address <= '0;
      r_grant_id      <= '0;
    end else if (w_gnt_vld) begin
      r_last          <= w_gnt;
      r_write_valid   <= 1'b1;
      r_write_data    <= w_sel.data;
      r_write_address <= w_sel.dest;
      r_grant_id      <= w_gnt;
    end else begin
      r_write_valid   <= 1'b0;
      r_write_data    <= '0;
      r_write_address <= '0;
    end
  end

  assign write_valid   = r_write_valid;
  assign write_data    = r_write_data;
  assign write_address = r_write_address;
  assign grant_id      = r_grant_id;

endmodule
